// File: rtl/wb_arb_pkg.sv
// Purpose: shared types and constants for the two-port Wishbone round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: arb_state_t (arbiter FSM encoding), grant bit indices, last-owner encodings.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } arb_state_t;

    // Bit positions within o_grant.
    localparam int GNT_A = 0;
    localparam int GNT_B = 1;

    // Encoding of the last_owner register; values match the grant indices.
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Purpose: counts stalled cycles while requests are outstanding and flags expiry.
// Latency: expire is combinational in the TIMEOUT-th consecutive busy cycle without progress.
// Backpressure: none; the counter restarts whenever progress is seen or nothing is outstanding.
// Ports: i_clk, i_rst_n (async active-low); busy (requests outstanding), progress (ack/err seen);
//        expire (one-cycle pulse). TIMEOUT=0 disables the watchdog.
module wb_arb_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic busy,
    input  logic progress,
    output logic expire
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Count value held during the TIMEOUT-th waiting cycle.
    localparam logic [WW-1:0] LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

    logic [WW-1:0] wd_q, wd_d;

    assign expire = (TIMEOUT != 0) && busy && !progress && (wd_q == LAST);

    always_comb begin
        wd_d = '0;
        if (busy && !progress) begin
            wd_d = expire ? '0 : wd_q + WW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Purpose: round-robin arbiter sharing one pipelined Wishbone bus between port A and port B.
// Latency: one cycle from cyc to grant; strobes, acks and errors pass through combinationally.
// Backpressure: owner sees slave stall or a full outstanding counter; non-owner is always stalled.
// Ports: i_clk, i_axi_reset_n; i_a_*/o_a_* and i_b_*/o_b_* master ports; o_cyc/o_stb/o_we/o_adr/
//        o_dat/o_sel + i_stall/i_ack/i_err slave side; o_grant (one-hot owner), o_timeout (pulse).
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int   AW               = 26,
    parameter int   DW               = 32,
    parameter int   LGMAXOUT         = 4,
    parameter int   TIMEOUT          = 1023,
    parameter logic OPT_ZERO_ON_IDLE = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_axi_reset_n,
    // port A
    input  logic              i_a_cyc,
    input  logic              i_a_stb,
    input  logic              i_a_we,
    input  logic [AW-1:0]     i_a_adr,
    input  logic [DW-1:0]     i_a_dat,
    input  logic [DW/8-1:0]   i_a_sel,
    output logic              o_a_stall,
    output logic              o_a_ack,
    output logic              o_a_err,
    // port B
    input  logic              i_b_cyc,
    input  logic              i_b_stb,
    input  logic              i_b_we,
    input  logic [AW-1:0]     i_b_adr,
    input  logic [DW-1:0]     i_b_dat,
    input  logic [DW/8-1:0]   i_b_sel,
    output logic              o_b_stall,
    output logic              o_b_ack,
    output logic              o_b_err,
    // arbitrated bus
    output logic              o_cyc,
    output logic              o_stb,
    output logic              o_we,
    output logic [AW-1:0]     o_adr,
    output logic [DW-1:0]     o_dat,
    output logic [DW/8-1:0]   o_sel,
    input  logic              i_stall,
    input  logic              i_ack,
    input  logic              i_err,
    // status
    output logic [1:0]        o_grant,
    output logic              o_timeout
);

    localparam int CW = LGMAXOUT + 1;
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {LGMAXOUT{1'b0}}};

    arb_state_t    state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d;

    logic own_a, own_b, owned;
    logic own_cyc, own_stb;
    logic full, cnt_nz;
    logic rsp_ok, ack_in, err_in, progress, expire, fail;
    logic accept;

    assign own_a  = (state_q == OWN_A);
    assign own_b  = (state_q == OWN_B);
    assign owned  = own_a | own_b;

    assign own_cyc = (own_a & i_a_cyc) | (own_b & i_b_cyc);
    assign own_stb = (own_a & i_a_stb) | (own_b & i_b_stb);

    assign full   = (cnt_q == FULL_CNT);
    assign cnt_nz = (cnt_q != '0);

    // Slave responses only count when something is actually outstanding for the owner.
    // Error wins over ack so the master never sees both in one cycle.
    assign rsp_ok   = owned & cnt_nz;
    assign err_in   = rsp_ok & i_err;
    assign ack_in   = rsp_ok & i_ack & ~i_err;
    assign progress = rsp_ok & (i_ack | i_err);
    assign fail     = err_in | expire;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst_n  (i_axi_reset_n),
        .busy     (cnt_nz),
        .progress (progress),
        .expire   (expire)
    );

    // Bus side: the abort latch drops cyc until the owner releases its own cyc.
    assign o_cyc  = own_cyc & ~abort_q;
    assign o_stb  = o_cyc & own_stb & ~full;
    assign accept = o_stb & ~i_stall;

    always_comb begin
        if (OPT_ZERO_ON_IDLE && !owned) begin
            o_we  = 1'b0;
            o_adr = '0;
            o_dat = '0;
            o_sel = '0;
        end else if (own_b) begin
            o_we  = i_b_we;
            o_adr = i_b_adr;
            o_dat = i_b_dat;
            o_sel = i_b_sel;
        end else begin
            o_we  = i_a_we;
            o_adr = i_a_adr;
            o_dat = i_a_dat;
            o_sel = i_a_sel;
        end
    end

    assign o_a_stall = ~own_a | i_stall | full | abort_q;
    assign o_b_stall = ~own_b | i_stall | full | abort_q;
    assign o_a_ack   = own_a & ack_in;
    assign o_b_ack   = own_b & ack_in;
    assign o_a_err   = own_a & fail;
    assign o_b_err   = own_b & fail;

    assign o_grant[GNT_A] = own_a;
    assign o_grant[GNT_B] = own_b;
    assign o_timeout      = expire;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        abort_d      = abort_q;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                abort_d = 1'b0;
                if (i_a_cyc && (!i_b_cyc || last_owner_q == OWNER_B)) begin
                    state_d = OWN_A;
                end else if (i_b_cyc) begin
                    state_d = OWN_B;
                end
            end
            OWN_A, OWN_B: begin
                if (!own_cyc) begin
                    // Owner released the bus: anything still pending is abandoned.
                    state_d      = IDLE;
                    last_owner_d = own_a ? OWNER_A : OWNER_B;
                    cnt_d        = '0;
                    abort_d      = 1'b0;
                end else if (fail) begin
                    // Cycle is being aborted, so nothing remains outstanding.
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else if (accept && !ack_in) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (!accept && ack_in) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_B;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Purpose: directed self-checking bench for wb_rr_arbiter (LGMAXOUT=2, TIMEOUT=8).
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit before the rising edge.
// Backpressure: slave stall held low; acks and errors issued by hand per step.
module tb_wb_rr_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;

    logic            i_clk;
    logic            i_axi_reset_n;
    logic            i_a_cyc, i_a_stb, i_a_we;
    logic [AW-1:0]   i_a_adr;
    logic [DW-1:0]   i_a_dat;
    logic [DW/8-1:0] i_a_sel;
    logic            o_a_stall, o_a_ack, o_a_err;
    logic            i_b_cyc, i_b_stb, i_b_we;
    logic [AW-1:0]   i_b_adr;
    logic [DW-1:0]   i_b_dat;
    logic [DW/8-1:0] i_b_sel;
    logic            o_b_stall, o_b_ack, o_b_err;
    logic            o_cyc, o_stb, o_we;
    logic [AW-1:0]   o_adr;
    logic [DW-1:0]   o_dat;
    logic [DW/8-1:0] o_sel;
    logic            i_stall, i_ack, i_err;
    logic [1:0]      o_grant;
    logic            o_timeout;

    int checks;
    int errors;

    wb_rr_arbiter #(
        .AW               (AW),
        .DW               (DW),
        .LGMAXOUT         (2),
        .TIMEOUT          (8),
        .OPT_ZERO_ON_IDLE (1'b1)
    ) dut (
        .i_clk         (i_clk),
        .i_axi_reset_n (i_axi_reset_n),
        .i_a_cyc       (i_a_cyc),
        .i_a_stb       (i_a_stb),
        .i_a_we        (i_a_we),
        .i_a_adr       (i_a_adr),
        .i_a_dat       (i_a_dat),
        .i_a_sel       (i_a_sel),
        .o_a_stall     (o_a_stall),
        .o_a_ack       (o_a_ack),
        .o_a_err       (o_a_err),
        .i_b_cyc       (i_b_cyc),
        .i_b_stb       (i_b_stb),
        .i_b_we        (i_b_we),
        .i_b_adr       (i_b_adr),
        .i_b_dat       (i_b_dat),
        .i_b_sel       (i_b_sel),
        .o_b_stall     (o_b_stall),
        .o_b_ack       (o_b_ack),
        .o_b_err       (o_b_err),
        .o_cyc         (o_cyc),
        .o_stb         (o_stb),
        .o_we          (o_we),
        .o_adr         (o_adr),
        .o_dat         (o_dat),
        .o_sel         (o_sel),
        .i_stall       (i_stall),
        .i_ack         (i_ack),
        .i_err         (i_err),
        .o_grant       (o_grant),
        .o_timeout     (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic nxt();
        @(negedge i_clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_axi_reset_n = 1'b0;
        i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_a_adr = '0; i_a_dat = '0; i_a_sel = '0;
        i_b_cyc = 0; i_b_stb = 0; i_b_we = 0; i_b_adr = '0; i_b_dat = '0; i_b_sel = '0;
        i_stall = 0; i_ack = 0; i_err = 0;

        // Reset state, with requests and responses already active.
        #2;
        i_a_cyc = 1; i_b_cyc = 1; i_ack = 1; i_err = 1;
        #1;
        chk("rst_cyc",     32'(o_cyc), 0);
        chk("rst_stb",     32'(o_stb), 0);
        chk("rst_grant",   32'(o_grant), 0);
        chk("rst_timeout", 32'(o_timeout), 0);
        chk("rst_a_stall", 32'(o_a_stall), 1);
        chk("rst_b_stall", 32'(o_b_stall), 1);
        chk("rst_acks",    32'({o_a_ack, o_b_ack, o_a_err, o_b_err}), 0);

        nxt(); #4;
        chk("rst_hold_grant", 32'(o_grant), 0);

        // Release: no grant in the release cycle, both stalled.
        nxt();
        i_ack = 0; i_err = 0; i_axi_reset_n = 1;
        #4;
        chk("rel_grant",   32'(o_grant), 0);
        chk("rel_a_stall", 32'(o_a_stall), 1);
        chk("rel_cyc",     32'(o_cyc), 0);

        // Contention: A wins first.
        nxt(); #4;
        chk("cont_grant_a", 32'(o_grant), 32'h1);
        chk("cont_a_stall", 32'(o_a_stall), 0);
        chk("cont_b_stall", 32'(o_b_stall), 1);
        chk("cont_cyc",     32'(o_cyc), 1);
        chk("cont_stb",     32'(o_stb), 0);

        nxt(); i_a_cyc = 0; #4;
        chk("a_drop_cyc", 32'(o_cyc), 0);

        nxt(); i_a_cyc = 1; #4;
        chk("idle_grant", 32'(o_grant), 0);

        // Both requesting again: B now wins.
        nxt();
        i_b_stb = 1; i_b_we = 1; i_b_adr = 26'h0000100; i_b_dat = 32'hA5A5_0001; i_b_sel = 4'hF;
        i_a_adr = 26'h3FF_FFFF; i_a_dat = 32'hDEAD_BEEF; i_a_sel = 4'h3;
        #4;
        chk("cont_grant_b", 32'(o_grant), 32'h2);
        chk("b_own_a_stall", 32'(o_a_stall), 1);
        chk("p0_stb", 32'(o_stb), 1);
        chk("p0_we",  32'(o_we), 1);
        chk("p0_adr", 32'(o_adr), 32'h0000100);
        chk("p0_dat", 32'(o_dat), 32'hA5A5_0001);
        chk("p0_sel", 32'(o_sel), 32'hF);
        chk("p0_cnt", 32'(dut.cnt_q), 0);

        nxt(); i_b_adr = 26'h0000104; i_b_dat = 32'hA5A5_0002; #4;
        chk("p1_cnt", 32'(dut.cnt_q), 1);
        chk("p1_adr", 32'(o_adr), 32'h0000104);
        nxt(); i_b_adr = 26'h0000108; i_b_dat = 32'hA5A5_0003; #4;
        chk("p2_cnt", 32'(dut.cnt_q), 2);
        nxt(); i_b_stb = 0; #4;
        chk("p3_cnt", 32'(dut.cnt_q), 3);
        chk("p3_stb", 32'(o_stb), 0);
        nxt(); i_ack = 1; #4;
        chk("p_ack1_b", 32'(o_b_ack), 1);
        chk("p_ack1_a", 32'(o_a_ack), 0);
        chk("p_ack1_cnt", 32'(dut.cnt_q), 3);
        nxt(); #4;
        chk("p_ack2_b", 32'(o_b_ack), 1);
        chk("p_ack2_a", 32'(o_a_ack), 0);
        chk("p_ack2_cnt", 32'(dut.cnt_q), 2);
        nxt(); #4;
        chk("p_ack3_b", 32'(o_b_ack), 1);
        chk("p_ack3_a", 32'(o_a_ack), 0);
        chk("p_ack3_cnt", 32'(dut.cnt_q), 1);
        nxt(); i_ack = 0; #4;
        chk("p_done_cnt", 32'(dut.cnt_q), 0);
        chk("p_done_ack", 32'(o_b_ack), 0);

        // Simultaneous accepted strobe and ack.
        nxt(); i_b_stb = 1; #4;
        chk("sim_cnt0", 32'(dut.cnt_q), 0);
        nxt(); i_ack = 1; #4;
        chk("sim_cnt1", 32'(dut.cnt_q), 1);
        chk("sim_ack",  32'(o_b_ack), 1);
        chk("sim_stb",  32'(o_stb), 1);
        nxt(); i_b_stb = 0; #4;
        chk("sim_hold", 32'(dut.cnt_q), 1);
        nxt(); i_ack = 0; #4;
        chk("sim_zero", 32'(dut.cnt_q), 0);

        // Full: four strobes accepted without acks.
        nxt(); i_b_stb = 1; #4;
        nxt(); #4;
        nxt(); #4;
        nxt(); #4;
        chk("full_pre_cnt", 32'(dut.cnt_q), 3);
        chk("full_pre_stb", 32'(o_stb), 1);
        nxt(); #4;
        chk("full_cnt",   32'(dut.cnt_q), 4);
        chk("full_stall", 32'(o_b_stall), 1);
        chk("full_stb",   32'(o_stb), 0);
        nxt(); i_ack = 1; #4;
        chk("full_ack_stb", 32'(o_stb), 0);
        chk("full_ack",     32'(o_b_ack), 1);
        nxt(); i_ack = 0; #4;
        chk("fifth_cnt",   32'(dut.cnt_q), 3);
        chk("fifth_stb",   32'(o_stb), 1);
        chk("fifth_stall", 32'(o_b_stall), 0);
        nxt(); i_b_stb = 0; i_ack = 1; #4;
        chk("fifth_acc_cnt", 32'(dut.cnt_q), 4);
        nxt(); #4;
        nxt(); #4;
        nxt(); #4;
        chk("drain_cnt", 32'(dut.cnt_q), 1);
        nxt(); i_ack = 0; i_b_cyc = 0; #4;
        chk("drain_zero", 32'(dut.cnt_q), 0);

        // Ack while idle is ignored; idle payload is zeroed.
        nxt(); i_ack = 1; #4;
        chk("idle_state", 32'(o_grant), 0);
        chk("idle_ack",   32'({o_a_ack, o_b_ack}), 0);
        chk("idle_adr",   32'(o_adr), 0);
        chk("idle_dat",   32'(o_dat), 0);

        // Timeout: one read from A, never acknowledged.
        nxt(); i_ack = 0; i_a_stb = 1; i_a_we = 0; i_a_adr = 26'h0000200; #4;
        chk("to_grant", 32'(o_grant), 32'h1);
        chk("to_adr",   32'(o_adr), 32'h0000200);
        chk("to_we",    32'(o_we), 0);
        chk("to_stb",   32'(o_stb), 1);
        nxt(); i_a_stb = 0; #4;
        chk("to_wait1", 32'(o_timeout), 0);
        for (int w = 2; w <= 7; w++) begin
            nxt(); #4;
            chk("to_wait", 32'(o_timeout), 0);
        end
        chk("to_wait7_err", 32'(o_a_err), 0);
        nxt(); #4;
        chk("to_pulse",   32'(o_timeout), 1);
        chk("to_a_err",   32'(o_a_err), 1);
        chk("to_a_ack",   32'(o_a_ack), 0);
        chk("to_b_err",   32'(o_b_err), 0);
        chk("to_cyc_hi",  32'(o_cyc), 1);
        nxt(); #4;
        chk("to_cyc_lo",  32'(o_cyc), 0);
        chk("to_pulse_end", 32'(o_timeout), 0);
        chk("to_err_end", 32'(o_a_err), 0);
        chk("to_stall",   32'(o_a_stall), 1);
        nxt(); i_a_cyc = 0; #4;
        chk("to_still_own", 32'(o_grant), 32'h1);

        // Slave error with simultaneous ack: error only, then abort.
        nxt(); i_a_cyc = 1; #4;
        nxt(); i_a_stb = 1; #4;
        chk("err_grant", 32'(o_grant), 32'h1);
        nxt(); i_a_stb = 0; i_err = 1; i_ack = 1; #4;
        chk("err_a_err", 32'(o_a_err), 1);
        chk("err_a_ack", 32'(o_a_ack), 0);
        chk("err_cyc",   32'(o_cyc), 1);
        nxt(); i_err = 0; i_ack = 0; #4;
        chk("err_abort_cyc", 32'(o_cyc), 0);
        chk("err_abort_err", 32'(o_a_err), 0);
        nxt(); i_a_cyc = 0; #4;

        // Reset in the middle of a burst with two outstanding.
        nxt(); i_a_cyc = 1; #4;
        nxt(); i_a_stb = 1; #4;
        nxt(); #4;
        nxt(); i_a_stb = 0; #4;
        chk("mid_cnt", 32'(dut.cnt_q), 2);
        #2; i_axi_reset_n = 0; #1;
        chk("mid_rst_cyc",   32'(o_cyc), 0);
        chk("mid_rst_grant", 32'(o_grant), 0);
        chk("mid_rst_cnt",   32'(dut.cnt_q), 0);
        chk("mid_rst_stall", 32'({o_a_stall, o_b_stall}), 32'h3);
        nxt(); #4;
        nxt(); i_axi_reset_n = 1; i_a_cyc = 0; i_ack = 1; #4;
        chk("late_ack0", 32'({o_a_ack, o_b_ack}), 0);
        nxt(); #4;
        chk("late_ack1", 32'({o_a_ack, o_b_ack}), 0);
        nxt(); i_ack = 0; i_a_cyc = 1; i_b_cyc = 1; #4;
        nxt(); #4;
        chk("post_rst_grant", 32'(o_grant), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter AW, 26: Wishbone word-address width.
REQ-002 Parameter DW, 32: Wishbone data width; DW/8 select bits.
REQ-003 Parameter LGMAXOUT, 4: log2 of the maximum outstanding (stb accepted, ack/err pending) requests per grant.
REQ-004 Parameter TIMEOUT, 1023: cycles without ack/err while outstanding>0 before a forced error; 0 disables.
REQ-005 Parameter OPT_ZERO_ON_IDLE, 1'b1: forces o_adr/o_dat/o_sel/o_we to zero when no grant is held.
REQ-006 One clock; reset is asynchronous and active-low: i_clk in 1, system clock; i_axi_reset_n in 1, asynchronous active-low reset.
REQ-007 i_a_cyc, i_a_stb, i_a_we in 1 each: port A (read master) request.
REQ-008 i_a_adr in AW, i_a_dat in DW, i_a_sel in DW/8: port A payload.
REQ-009 o_a_stall, o_a_ack, o_a_err out 1 each: port A responses.
REQ-010 Port B (write master) uses the identical set i_b_* / o_b_*.
REQ-011 o_cyc, o_stb, o_we out 1; o_adr out AW; o_dat out DW; o_sel out DW/8: arbitrated bus.
REQ-012 i_stall, i_ack, i_err in 1 each: slave responses.
REQ-013 o_grant out 2: one-hot current owner (bit0=A, bit1=B); o_timeout out 1: one-cycle pulse on watchdog expiry.

Function
REQ-014 The state machine SHALL have states IDLE, OWN_A and OWN_B, registered on i_clk.
REQ-015 In IDLE, a port with cyc=1 SHALL be granted on the next edge; both requesting SHALL grant the port not served last (last_owner register, reset value B, so A wins first).
REQ-016 In the cycle a grant is decided, both ports SHALL see stall=1, and o_cyc/o_stb SHALL be 0.
REQ-017 While OWN_x: o_cyc=i_x_cyc, o_stb=i_x_stb AND NOT full, payload muxed from port x, o_x_stall=i_stall OR full, and the non-owner stall=1, ack=0 and err=0.
REQ-018 i_ack/i_err SHALL route combinationally to the owner only, and never both.
REQ-019 The outstanding counter (LGMAXOUT+1 bits) SHALL increment on o_stb AND NOT i_stall, decrement on i_ack OR i_err, and hold when both occur in one cycle.
REQ-020 full SHALL mean counter = 2**LGMAXOUT; a full counter SHALL never increment.
REQ-021 An OWN_x to IDLE transition SHALL occur when i_x_cyc=0 (counter cleared, pending acks discarded, last_owner<=x), with no direct OWN_A to OWN_B transition.
REQ-022 On i_err the owner SHALL see o_x_err=1 that cycle; o_cyc SHALL drop the next cycle (abort latch) until the owner drops cyc.
REQ-023 The watchdog SHALL count cycles with counter>0 and no ack/err and clear otherwise; at TIMEOUT it SHALL pulse o_timeout, assert o_x_err to the owner for one cycle, and behave as REQ-022.
REQ-024 Slave ack/err arriving while IDLE or the counter is zero SHALL be ignored.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE, counter=0, watchdog=0, last_owner=B, abort latch=0.
REQ-026 During reset, o_cyc, o_stb, o_grant, o_timeout and all acks/errs SHALL be 0, and both stalls 1.
REQ-027 A mid-transaction reset SHALL discard outstanding state, with no ack/err delivered afterward for it.
REQ-028 Deassertion SHALL take effect on the first i_clk edge after reset goes high; no grant is issued in that same cycle.

Structure
REQ-029 Package wb_arb_pkg SHALL hold the arb_state_t enum (IDLE=2'b00, OWN_A=2'b01, OWN_B=2'b10) and the grant-index constants.
REQ-030 The watchdog SHALL be one sub-module, wb_arb_watchdog (params TIMEOUT; inputs busy, progress; output expire).
REQ-031 Other logic SHALL be in wb_rr_arbiter.

Verification
REQ-032 Contention: A and B cyc=1 in the same cycle after reset -> o_grant=01 next cycle; after A drops cyc with both still requesting -> o_grant=10.
REQ-033 Pipelining: B issues 3 writes, i_stall=0, acks 2 cycles later -> counter 1,2,3 then down to 0, three o_b_ack, o_a_ack never 1.
REQ-034 Full: LGMAXOUT=2, slave withholds ack -> after 4 accepted strobes o_b_stall=1 and o_stb=0; one ack -> the 5th strobe is accepted.
REQ-035 Timeout: TIMEOUT=8, one read, no ack -> at the 8th wait cycle o_timeout=1 and o_a_err=1 for one cycle; o_cyc=0 next cycle.
REQ-036 Reset mid-burst: 2 outstanding, i_axi_reset_n low -> o_cyc=0 immediately; a late i_ack after release produces no o_a_ack/o_b_ack.
REQ-037 Simultaneous ack+stb: counter=1, accepted stb and ack in one cycle -> counter stays 1.
